// File: rtl/control_sequencer.sv
// Six-step one-hot stepper and instruction decoder. Steps 1-3 fetch, steps 4-6 execute the
// opcode on ir. The step register and halt flag are the only state; every strobe is decoded
// combinationally from the current step, ir and flags.
module control_sequencer #(
  parameter bit HALT_EN   = 1'b1,
  parameter bit SKIP_IDLE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] ir,
  input  logic [3:0] flags,
  output logic [5:0] cpt,
  output logic       halted,
  output logic       IIAR,
  output logic       OIAR,
  output logic       IIR,
  output logic       IACC,
  output logic       OACC,
  output logic       ITEMP,
  output logic       IFLAGS,
  output logic       IR0,
  output logic       IR1,
  output logic       IR2,
  output logic       IR3,
  output logic       OR0,
  output logic       OR1,
  output logic       OR2,
  output logic       OR3,
  output logic       IDISP_REG,
  output logic       OZERO_REG,
  output logic       IMAR,
  output logic       ORAM,
  output logic       IRAM,
  output logic       BUS1,
  output logic [2:0] alu_op
);

  typedef enum logic [5:0] {
    Step1 = 6'b000001,
    Step2 = 6'b000010,
    Step3 = 6'b000100,
    Step4 = 6'b001000,
    Step5 = 6'b010000,
    Step6 = 6'b100000
  } step_e;

  typedef struct packed {
    logic       iiar, oiar, iir, iacc, oacc, itemp, iflags;
    logic [3:0] ir_ld;
    logic [3:0] or_en;
    logic       idisp, imar, oram, iram, bus1;
    logic [2:0] alu_op;
  } strobes_t;

  localparam logic [2:0] OpLd    = 3'd0;
  localparam logic [2:0] OpSt    = 3'd1;
  localparam logic [2:0] OpData  = 3'd2;
  localparam logic [2:0] OpJmpr  = 3'd3;
  localparam logic [2:0] OpJmp   = 3'd4;
  localparam logic [2:0] OpJcaez = 3'd5;
  localparam logic [2:0] OpClf   = 3'd6;
  localparam logic [2:0] AluCmp  = 3'd7;

  // Full strobe set for one step of the instruction in ir_v; all-zero means an idle step.
  function automatic strobes_t decode(input step_e step, input logic [7:0] ir_v,
                                      input logic [3:0] flags_v);
    strobes_t   s;
    logic [1:0] ra;
    logic [1:0] rb;
    s  = '0;
    ra = ir_v[3:2];
    rb = ir_v[1:0];
    case (step)
      Step1: begin s.oiar = 1'b1; s.bus1 = 1'b1; s.imar = 1'b1; s.iacc = 1'b1; end
      Step2: begin s.oram = 1'b1; s.iir = 1'b1; end
      Step3: begin s.oacc = 1'b1; s.iiar = 1'b1; end
      default: begin
        if (ir_v[7]) begin
          if (step == Step4) begin
            s.or_en[rb] = 1'b1; s.itemp = 1'b1;
          end else if (step == Step5) begin
            s.or_en[ra] = 1'b1; s.alu_op = ir_v[6:4]; s.iacc = 1'b1; s.iflags = 1'b1;
          end else if (step == Step6 && ir_v[6:4] != AluCmp) begin
            s.oacc = 1'b1; s.ir_ld[rb] = 1'b1;
          end
        end else begin
          case (ir_v[6:4])
            OpLd: begin
              if (step == Step4) begin s.or_en[ra] = 1'b1; s.imar = 1'b1; end
              else if (step == Step5) begin s.oram = 1'b1; s.ir_ld[rb] = 1'b1; end
            end
            OpSt: begin
              if (step == Step4) begin s.or_en[ra] = 1'b1; s.imar = 1'b1; end
              else if (step == Step5) begin s.or_en[rb] = 1'b1; s.iram = 1'b1; end
            end
            OpData: begin
              if (step == Step4) begin
                s.bus1 = 1'b1; s.oiar = 1'b1; s.imar = 1'b1; s.iacc = 1'b1;
              end else if (step == Step5) begin
                s.oram = 1'b1; s.ir_ld[rb] = 1'b1;
              end else if (step == Step6) begin
                s.oacc = 1'b1; s.iiar = 1'b1;
              end
            end
            OpJmpr: begin
              if (step == Step4) begin s.or_en[rb] = 1'b1; s.iiar = 1'b1; end
            end
            OpJmp: begin
              if (step == Step4) begin s.oiar = 1'b1; s.imar = 1'b1; end
              else if (step == Step5) begin s.oram = 1'b1; s.iiar = 1'b1; end
            end
            OpJcaez: begin
              if (step == Step4) begin
                s.bus1 = 1'b1; s.oiar = 1'b1; s.imar = 1'b1; s.iacc = 1'b1;
              end else if (step == Step5) begin
                s.oacc = 1'b1; s.iiar = 1'b1;
              end else if (step == Step6 && |(flags_v & ir_v[3:0])) begin
                s.oram = 1'b1; s.iiar = 1'b1;
              end
            end
            OpClf: begin
              // Flags clear by loading the ALU result of ACC-path ADD with the constant 1.
              if (step == Step4) begin s.bus1 = 1'b1; s.iflags = 1'b1; end
            end
            default: begin
              // 0111: OUT when ir[3]=1; HLT (no strobes) otherwise.
              if (step == Step4 && ir_v[3]) begin s.or_en[rb] = 1'b1; s.idisp = 1'b1; end
            end
          endcase
        end
      end
    endcase
    return s;
  endfunction

  step_e    cpt_q;
  step_e    cpt_d;
  logic     halted_q;
  logic     halt_now;
  logic     active;
  strobes_t str;

  // Next step: rotate, enter halt on HLT, or jump back to s1 past trailing idle steps.
  always_comb begin
    cpt_d    = step_e'({cpt_q[4:0], cpt_q[5]});
    halt_now = 1'b0;
    if (HALT_EN && cpt_q == Step3 && ir[7:3] == 5'b01110) begin
      halt_now = 1'b1;
    end else if (SKIP_IDLE && (cpt_d == Step4 || cpt_d == Step5 || cpt_d == Step6) &&
                 decode(cpt_d, ir, flags) == '0) begin
      cpt_d = Step1;
    end
  end

  // Step register and halt flag with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpt_q    <= Step1;
      halted_q <= 1'b0;
    end else if (run && !halted_q) begin
      cpt_q <= cpt_d;
      if (halt_now) halted_q <= 1'b1;
    end
  end

  // Strobes are suppressed during reset, hold and halt.
  always_comb begin
    active    = reset && run && !halted_q;
    str       = active ? decode(cpt_q, ir, flags) : '0;
    OZERO_REG = active && !(str.oiar || str.oacc || str.oram || (|str.or_en));
  end

  assign cpt       = cpt_q;
  assign halted    = halted_q;
  assign IIAR      = str.iiar;
  assign OIAR      = str.oiar;
  assign IIR       = str.iir;
  assign IACC      = str.iacc;
  assign OACC      = str.oacc;
  assign ITEMP     = str.itemp;
  assign IFLAGS    = str.iflags;
  assign IR0       = str.ir_ld[0];
  assign IR1       = str.ir_ld[1];
  assign IR2       = str.ir_ld[2];
  assign IR3       = str.ir_ld[3];
  assign OR0       = str.or_en[0];
  assign OR1       = str.or_en[1];
  assign OR2       = str.or_en[2];
  assign OR3       = str.or_en[3];
  assign IDISP_REG = str.idisp;
  assign IMAR      = str.imar;
  assign ORAM      = str.oram;
  assign IRAM      = str.iram;
  assign BUS1      = str.bus1;
  assign alu_op    = str.alu_op;

endmodule
